pipe_hazard_ctrl: RTL and testbench

//  Hazard/sequencing controller for the 5-stage pipeline. Drives Nop (hold PcUnit+IFID) and IF_Flush into IFID and

---
 rtl/pipe_hazard_ctrl_pkg.sv | 36 +++
 rtl/pipe_hazard_ctrl_if.sv | 27 ++
 rtl/pipe_hazard_ctrl_md_busy_counter.sv | 26 ++
 rtl/pipe_hazard_ctrl.sv | 90 +++++++++
 tb/tb_pipe_hazard_ctrl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared decode constants, FSM state encoding and instruction-class helpers for the hazard controller.
// Combinational helpers only; no timing or flow control of their own.
package pipe_hazard_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_MFHI   = 6'h10;
    localparam logic [5:0] F_MFLO   = 6'h12;
    localparam logic [5:0] F_MULT   = 6'h18;
    localparam logic [5:0] F_MULTU  = 6'h19;
    localparam logic [5:0] F_DIV    = 6'h1A;
    localparam logic [5:0] F_DIVU   = 6'h1B;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MD_WAIT    = 2'd2
    } hz_state_t;

    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    endfunction

    function automatic logic is_md(input logic [5:0] op, input logic [5:0] funct);
        return (op == OP_RTYPE) &&
               ((funct == F_MULT) || (funct == F_MULTU) || (funct == F_DIV) || (funct == F_DIVU));
    endfunction

    function automatic logic is_hilo(input logic [5:0] op, input logic [5:0] funct);
        return (op == OP_RTYPE) && ((funct == F_MFHI) || (funct == F_MFLO));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage decode inputs and pipeline hold/flush outputs of the hazard controller.
// Pure wiring bundle; the controller is the slave, the pipeline side is the master.
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 16);
    logic [5:0]       op;
    logic [5:0]       funct;
    logic [4:0]       rfReSel1;
    logic [4:0]       rfReSel2;
    logic             IDEX_MemRead;
    logic [4:0]       IDEX_Rt;
    logic             Branch_Taken;
    logic             Jump;
    logic             Nop;
    logic             IF_Flush;
    logic             IDEX_Flush;
    logic             MD_Busy;
    logic [CNT_W-1:0] StallCount;

    modport master (
        output op, funct, rfReSel1, rfReSel2, IDEX_MemRead, IDEX_Rt, Branch_Taken, Jump,
        input  Nop, IF_Flush, IDEX_Flush, MD_Busy, StallCount
    );

    modport slave (
        input  op, funct, rfReSel1, rfReSel2, IDEX_MemRead, IDEX_Rt, Branch_Taken, Jump,
        output Nop, IF_Flush, IDEX_Flush, MD_Busy, StallCount
    );
endinterface

// File: rtl/pipe_hazard_ctrl_md_busy_counter.sv
// Tracks how long HI/LO stay busy after a mult/div leaves ID: load wins over countdown.
// busy rises the cycle after load and stays high for exactly MD_LATENCY cycles; no backpressure.
module md_busy_counter #(
    parameter int MD_LATENCY = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic busy
);
    localparam int W = $clog2(MD_LATENCY + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= W'(MD_LATENCY);
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign busy = (cnt != '0);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch/jump flushes and stalls behind the mult/div unit.
// Outputs are same-cycle combinational from state, md counter and ID/EX inputs; Nop holds PC and IFID.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input logic             Clk,
    input logic             Reset,
    pipe_hazard_ctrl_if.slave hz
);
    hz_state_t        state;
    logic             load_use;
    logic             md_busy;
    logic             md_haz;
    logic             md_load;
    logic             nop;
    logic             if_flush;
    logic             idex_flush;
    logic [CNT_W-1:0] stall_cnt;

    // Register $0 is hardwired, so a load into it can never be a real dependency.
    assign load_use = hz.IDEX_MemRead && (hz.IDEX_Rt != 5'd0) &&
                      ((hz.IDEX_Rt == hz.rfReSel1) ||
                       (uses_rt(hz.op) && (hz.IDEX_Rt == hz.rfReSel2)));

    assign md_haz = (is_md(hz.op, hz.funct) || is_hilo(hz.op, hz.funct)) && md_busy;

    always_comb begin
        nop        = 1'b0;
        if_flush   = 1'b0;
        idex_flush = 1'b0;
        if (Reset) begin
            if_flush   = 1'b1;
            idex_flush = 1'b1;
        end else if (hz.Branch_Taken) begin
            if_flush   = 1'b1;
            idex_flush = 1'b1;
        end else if ((state == ST_RUN) && load_use) begin
            nop        = 1'b1;
            idex_flush = 1'b1;
        end else if (md_haz) begin
            nop        = 1'b1;
            idex_flush = 1'b1;
        end else if (hz.Jump) begin
            if_flush   = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ST_RUN;
        end else if (hz.Branch_Taken) begin
            state <= ST_RUN;
        end else if ((state == ST_RUN) && load_use) begin
            state <= ST_LOAD_STALL;
        end else if (md_haz) begin
            state <= ST_MD_WAIT;
        end else begin
            state <= ST_RUN;
        end
    end

    // Only an MD op that actually advances out of ID (not held, not squashed) occupies HI/LO.
    assign md_load = is_md(hz.op, hz.funct) && !nop && !if_flush && !hz.Branch_Taken;

    md_busy_counter #(
        .MD_LATENCY (MD_LATENCY)
    ) u_md_busy (
        .clk  (Clk),
        .rst  (Reset),
        .load (md_load),
        .busy (md_busy)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_cnt <= '0;
        end else if (nop && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign hz.Nop        = nop;
    assign hz.IF_Flush   = if_flush;
    assign hz.IDEX_Flush = idex_flush;
    assign hz.MD_Busy    = md_busy && !Reset;
    assign hz.StallCount = stall_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: single-cycle decode table plus multi-cycle stall/flush/reset sequences.
module tb_pipe_hazard_ctrl;
    logic Clk = 1'b0;
    logic Reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 Clk = ~Clk;

    pipe_hazard_ctrl_if #(.CNT_W(16)) bif ();
    pipe_hazard_ctrl_if #(.CNT_W(4))  sif ();

    // Narrow-counter twin sees identical stimulus so saturation is reachable quickly.
    assign sif.op           = bif.op;
    assign sif.funct        = bif.funct;
    assign sif.rfReSel1     = bif.rfReSel1;
    assign sif.rfReSel2     = bif.rfReSel2;
    assign sif.IDEX_MemRead = bif.IDEX_MemRead;
    assign sif.IDEX_Rt      = bif.IDEX_Rt;
    assign sif.Branch_Taken = bif.Branch_Taken;
    assign sif.Jump         = bif.Jump;

    pipe_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(16)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .hz    (bif.slave)
    );

    pipe_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(4)) dut_sat (
        .Clk   (Clk),
        .Reset (Reset),
        .hz    (sif.slave)
    );

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       mr;
        logic [4:0] idrt;
        logic       bt;
        logic       jmp;
        logic       e_nop;
        logic       e_iff;
        logic       e_idf;
    } vec_t;

    vec_t vt[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [5:0] o, input logic [5:0] f, input logic [4:0] s,
                         input logic [4:0] t, input logic m, input logic [4:0] er,
                         input logic b, input logic j);
        bif.op           = o;
        bif.funct        = f;
        bif.rfReSel1     = s;
        bif.rfReSel2     = t;
        bif.IDEX_MemRead = m;
        bif.IDEX_Rt      = er;
        bif.Branch_Taken = b;
        bif.Jump         = j;
    endtask

    task automatic idle();
        drive(6'h00, 6'h20, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        idle();
        tick();
        Reset = 1'b0;
    endtask

    task automatic chk_out(input string nm, input logic e_nop, input logic e_iff, input logic e_idf);
        chk({nm, ".Nop"},        32'(bif.Nop),        32'(e_nop));
        chk({nm, ".IF_Flush"},   32'(bif.IF_Flush),   32'(e_iff));
        chk({nm, ".IDEX_Flush"}, 32'(bif.IDEX_Flush), 32'(e_idf));
    endtask

    initial begin
        //          op     funct  rs  rt  mr  idrt bt  jmp  nop iff idf
        vt[0]  = '{6'h00, 6'h20, 5, 6, 1, 5, 0, 0, 1, 0, 1};  // add uses rs=5
        vt[1]  = '{6'h00, 6'h20, 0, 0, 1, 0, 0, 0, 0, 0, 0};  // load into $0
        vt[2]  = '{6'h0F, 6'h00, 0, 5, 1, 5, 0, 0, 0, 0, 0};  // lui: rt not a source
        vt[3]  = '{6'h2B, 6'h00, 1, 5, 1, 5, 0, 0, 1, 0, 1};  // sw uses rt
        vt[4]  = '{6'h23, 6'h00, 2, 5, 1, 5, 0, 0, 0, 0, 0};  // lw: rt is dest
        vt[5]  = '{6'h04, 6'h00, 1, 5, 1, 5, 0, 0, 1, 0, 1};  // beq uses rt
        vt[6]  = '{6'h00, 6'h20, 1, 5, 1, 5, 0, 0, 1, 0, 1};  // R-type uses rt
        vt[7]  = '{6'h02, 6'h00, 0, 0, 0, 0, 0, 1, 0, 1, 0};  // j only
        vt[8]  = '{6'h02, 6'h00, 0, 0, 0, 0, 1, 1, 0, 1, 1};  // branch + jump
        vt[9]  = '{6'h00, 6'h20, 5, 6, 1, 5, 1, 0, 0, 1, 1};  // branch cancels loaduse
        vt[10] = '{6'h00, 6'h08, 5, 0, 1, 5, 0, 1, 1, 0, 1};  // jr behind load: stall wins
        vt[11] = '{6'h00, 6'h10, 0, 0, 1, 5, 0, 0, 0, 0, 0};  // mfhi, HI/LO idle
        vt[12] = '{6'h00, 6'h20, 5, 6, 0, 5, 0, 0, 0, 0, 0};  // EX not a load
        vt[13] = '{6'h05, 6'h00, 3, 7, 1, 7, 0, 0, 1, 0, 1};  // bne uses rt
        vt[14] = '{6'h0F, 6'h00, 7, 0, 1, 7, 0, 0, 1, 0, 1};  // rs always a source

        Reset = 1'b1;
        idle();
        #2;
        chk_out("reset_hold", 1'b0, 1'b1, 1'b1);
        chk("reset_hold.MD_Busy", 32'(bif.MD_Busy), 32'd0);
        tick();
        Reset = 1'b0;
        #1;
        chk("post_reset.StallCount", 32'(bif.StallCount), 32'd0);
        chk_out("post_reset", 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 15; i++) begin
            do_reset();
            drive(vt[i].op, vt[i].funct, vt[i].rs, vt[i].rt, vt[i].mr, vt[i].idrt, vt[i].bt, vt[i].jmp);
            #1;
            chk_out($sformatf("vec%0d", i), vt[i].e_nop, vt[i].e_iff, vt[i].e_idf);
        end

        // Load-use: exactly one stall cycle, loaduse ignored in LOAD_STALL
        do_reset();
        drive(6'h00, 6'h20, 5'd5, 5'd6, 1'b1, 5'd5, 1'b0, 1'b0);
        #1;
        chk_out("lu_c1", 1'b1, 1'b0, 1'b1);
        tick();
        chk_out("lu_c2", 1'b0, 1'b0, 1'b0);
        chk("lu_c2.StallCount", 32'(bif.StallCount), 32'd1);
        idle();
        tick();
        chk("lu_c3.StallCount", 32'(bif.StallCount), 32'd1);

        // mult leaves ID, mfhi waits four cycles
        do_reset();
        drive(6'h00, 6'h18, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        chk_out("mult_id", 1'b0, 1'b0, 1'b0);
        chk("mult_id.MD_Busy", 32'(bif.MD_Busy), 32'd0);
        tick();
        drive(6'h00, 6'h10, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk_out($sformatf("mfhi_wait%0d", k), 1'b1, 1'b0, 1'b1);
            chk($sformatf("mfhi_wait%0d.MD_Busy", k), 32'(bif.MD_Busy), 32'd1);
            tick();
        end
        chk_out("mfhi_go", 1'b0, 1'b0, 1'b0);
        chk("mfhi_go.MD_Busy", 32'(bif.MD_Busy), 32'd0);
        chk("mfhi_go.StallCount", 32'(bif.StallCount), 32'd4);

        // Branch during MD_WAIT: flush same cycle, counter keeps running
        do_reset();
        drive(6'h00, 6'h1A, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        drive(6'h00, 6'h12, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        chk_out("mdw_stall", 1'b1, 1'b0, 1'b1);
        tick();
        bif.Branch_Taken = 1'b1;
        #1;
        chk_out("mdw_branch", 1'b0, 1'b1, 1'b1);
        tick();
        idle();
        #1;
        chk_out("mdw_after", 1'b0, 1'b0, 1'b0);
        chk("mdw_after.MD_Busy", 32'(bif.MD_Busy), 32'd1);
        chk("mdw_after.StallCount", 32'(bif.StallCount), 32'd1);

        // Branch during LOAD_STALL
        do_reset();
        drive(6'h00, 6'h20, 5'd5, 5'd6, 1'b1, 5'd5, 1'b0, 1'b0);
        tick();
        bif.Branch_Taken = 1'b1;
        #1;
        chk_out("ls_branch", 1'b0, 1'b1, 1'b1);
        tick();
        idle();
        #1;
        chk_out("ls_after", 1'b0, 1'b0, 1'b0);

        // Squashed MD ops never occupy HI/LO
        do_reset();
        drive(6'h00, 6'h19, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        chk("md_bt_flushed.MD_Busy", 32'(bif.MD_Busy), 32'd0);
        do_reset();
        drive(6'h00, 6'h1B, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1);
        #1;
        chk("md_jmp.IF_Flush", 32'(bif.IF_Flush), 32'd1);
        tick();
        chk("md_jmp_flushed.MD_Busy", 32'(bif.MD_Busy), 32'd0);

        // Jump behind a load-use: stall first, flush next cycle
        do_reset();
        drive(6'h00, 6'h08, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b1);
        #1;
        chk_out("jlu_c1", 1'b1, 1'b0, 1'b1);
        tick();
        chk_out("jlu_c2", 1'b0, 1'b1, 1'b0);

        // Loaduse and mdhaz together: one LOAD_STALL then MD stalls until counter drains
        do_reset();
        drive(6'h00, 6'h18, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        drive(6'h00, 6'h18, 5'd5, 5'd6, 1'b1, 5'd5, 1'b0, 1'b0);
        #1;
        chk_out("both_c1", 1'b1, 1'b0, 1'b1);
        tick();
        chk_out("both_c2", 1'b1, 1'b0, 1'b1);
        bif.IDEX_MemRead = 1'b0;
        tick();
        tick();
        tick();
        chk_out("both_c5", 1'b0, 1'b0, 1'b0);
        chk("both_c5.StallCount", 32'(bif.StallCount), 32'd4);

        // Reset in MD_WAIT clears everything
        do_reset();
        drive(6'h00, 6'h18, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        drive(6'h00, 6'h10, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        Reset = 1'b1;
        #1;
        chk_out("rst_mdw", 1'b0, 1'b1, 1'b1);
        chk("rst_mdw.MD_Busy", 32'(bif.MD_Busy), 32'd0);
        tick();
        Reset = 1'b0;
        #1;
        chk_out("rst_mdw_after", 1'b0, 1'b0, 1'b0);
        chk("rst_mdw_after.MD_Busy", 32'(bif.MD_Busy), 32'd0);
        chk("rst_mdw_after.StallCount", 32'(bif.StallCount), 32'd0);

        // Saturation: 20 stall cycles (alternating RUN/LOAD_STALL)
        do_reset();
        drive(6'h00, 6'h20, 5'd5, 5'd6, 1'b1, 5'd5, 1'b0, 1'b0);
        for (int k = 0; k < 30; k++) tick();
        chk("sat15.StallCount_w4", 32'(sif.StallCount), 32'hF);
        for (int k = 0; k < 10; k++) tick();
        chk("sat.StallCount_w16", 32'(bif.StallCount), 32'd20);
        chk("sat.StallCount_w4", 32'(sif.StallCount), 32'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
